// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file writeback path.
package regfile_pkg;

  localparam int DEF_DATA_PATH_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH      = 4;
  localparam int NUM_REGS            = 2 ** DEF_ADDR_WIDTH;

  // Producer index: ALU results on src0, load-unit results on src1.
  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

  // One writeback packet as it travels to the register file.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]      addr;
    logic [DEF_DATA_PATH_WIDTH-1:0] data;
  } wb_pkt_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter. The priority pointer moves only when
// the caller reports an accepted transfer through 'advance', so a stalled
// grant keeps its priority. Shared with future read-port arbitration.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  src_e prio_q, prio_d;

  // Grant the lone requester, or on conflict the one holding priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio_q == SRC_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // After an accepted transfer the other requester wins the next conflict.
  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      prio_d = grant[0] ? SRC_LOAD : SRC_ALU;
    end
  end

  // Priority pointer; reset gives the ALU the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= SRC_ALU;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-side initiator: merges ALU and load-unit writebacks
// onto one registered write port (latency 1) and keeps a busy scoreboard
// of destinations with outstanding writes.
// Build option REGFILE_WB_R0_ZERO_EN: register 0 is hardwired zero; writes
// to it are accepted but never issued, and claims of it are ignored.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s0_valid,
  output logic                         s0_ready,
  input  logic [ADDR_WIDTH-1:0]        s0_addr,
  input  logic [DATA_PATH_WIDTH-1:0]   s0_data,
  input  logic                         s1_valid,
  output logic                         s1_ready,
  input  logic [ADDR_WIDTH-1:0]        s1_addr,
  input  logic [DATA_PATH_WIDTH-1:0]   s1_data,
  input  logic                         wb_hold,
  input  logic                         claim_valid,
  input  logic [ADDR_WIDTH-1:0]        claim_addr,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_PATH_WIDTH-1:0]   rf_wdata,
  output logic [(2**ADDR_WIDTH)-1:0]   busy
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [1:0]                 grant;
  logic                       hs;
  src_e                       sel_src;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [DATA_PATH_WIDTH-1:0] sel_data;
  logic                       wr_fire;
  logic                       claim_ok;

  logic                       rf_wen_q;
  logic [ADDR_WIDTH-1:0]      rf_waddr_q;
  logic [DATA_PATH_WIDTH-1:0] rf_wdata_q;
  logic [NREGS-1:0]           busy_q, busy_d;

  // Readiness depends only on valids (via the grant) and the hold.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({s1_valid, s0_valid}),
    .advance (hs),
    .grant   (grant)
  );

  assign s0_ready = grant[0] & ~wb_hold;
  assign s1_ready = grant[1] & ~wb_hold;
  assign hs       = (s0_valid & s0_ready) | (s1_valid & s1_ready);
  assign sel_src  = grant[1] ? SRC_LOAD : SRC_ALU;

  // Mux the granted producer's packet toward the write register.
  always_comb begin
    sel_addr = s0_addr;
    sel_data = s0_data;
    if (sel_src == SRC_LOAD) begin
      sel_addr = s1_addr;
      sel_data = s1_data;
    end
  end

`ifdef REGFILE_WB_R0_ZERO_EN
  assign wr_fire  = hs & (sel_addr != '0);
  assign claim_ok = claim_valid & (claim_addr != '0);
`else
  assign wr_fire  = hs;
  assign claim_ok = claim_valid;
`endif

  // Write port: pulse enable one cycle after a handshake, hold addr/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q <= wr_fire;
      if (wr_fire) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
    end
  end

  // Scoreboard next state: completed write clears, claim sets and wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[claim_addr] = 1'b1;
    end
`ifdef REGFILE_WB_R0_ZERO_EN
    busy_d[0] = 1'b0;
`endif
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this bit array is state issue logic trusts, so it is reset unlike a data RAM.
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic, all checked against a transaction-level model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

`ifdef REGFILE_WB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk, rst_n;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [3:0]  s0_addr, s1_addr, claim_addr, rf_waddr;
  logic [7:0]  s0_data, s1_data, rf_wdata;
  logic        wb_hold, claim_valid, rf_wen;
  logic [15:0] busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  bit      m_wen;
  wb_pkt_t m_last_wr;
  bit      m_busy [NUM_REGS];
  int      m_last_src;  // source granted at the most recent accepted handshake

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wb_hold(wb_hold), .claim_valid(claim_valid), .claim_addr(claim_addr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_wen          = 1'b0;
    m_last_wr.addr = '0;
    m_last_wr.data = '0;
    for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
    m_last_src = 1;  // so src0 wins the first conflict
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s0_addr = '0; s0_data = '0;
    s1_valid = 0; s1_addr = '0; s1_data = '0;
    wb_hold = 0; claim_valid = 0; claim_addr = '0;
  endtask

  // Called at posedge+1; resets the DUT and checks the reset values.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_wen",   32'(rf_wen),   32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One cycle: drive at posedge+1, compare at negedge, advance model, return at posedge+1.
  task automatic step(input bit v0, input logic [3:0] a0, input logic [7:0] d0,
                      input bit v1, input logic [3:0] a1, input logic [7:0] d1,
                      input bit hold, input bit cv, input logic [3:0] ca);
    bit r0, r1;
    bit nb [NUM_REGS];
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    wb_hold = hold; claim_valid = cv; claim_addr = ca;
    r0 = 0; r1 = 0;
    if (!hold) begin
      if (v0 && v1) begin
        if (m_last_src == 0) r1 = 1; else r0 = 1;
      end else begin
        r0 = v0;
        r1 = v1;
      end
    end
    @(negedge clk);
    check("s0_ready", 32'(s0_ready), 32'(r0));
    check("s1_ready", 32'(s1_ready), 32'(r1));
    check("rf_wen",   32'(rf_wen),   32'(m_wen));
    if (m_wen) begin
      check("rf_waddr", 32'(rf_waddr), 32'(m_last_wr.addr));
      check("rf_wdata", 32'(rf_wdata), 32'(m_last_wr.data));
    end
    check("busy", 32'(busy), 32'(model_busy()));
    // Scoreboard: write completion clears, a claim sets and overrides.
    nb = m_busy;
    if (m_wen) nb[m_last_wr.addr] = 1'b0;
    if (cv && !(R0Z && ca == 4'd0)) nb[ca] = 1'b1;
    m_busy = nb;
    // Write port.
    m_wen = 1'b0;
    if (r0 || r1) begin
      m_last_src = r0 ? 0 : 1;
      if (!(R0Z && (r0 ? a0 : a1) == 4'd0)) begin
        m_wen          = 1'b1;
        m_last_wr.addr = r0 ? a0 : a1;
        m_last_wr.data = r0 ? d0 : d1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single source write.
    step(1, 4'd3, 8'hA5, 0, 4'd0, 8'h00, 0, 0, 4'd0);
    check("t1_wen",   32'(rf_wen),   32'd1);
    check("t1_waddr", 32'(rf_waddr), 32'd3);
    check("t1_wdata", 32'(rf_wdata), 32'hA5);
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 4'd0);
    check("t1_wen_off", 32'(rf_wen), 32'd0);

    // Conflict fairness from a fresh pointer: s0, s1, s0, s1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 0, 0, 4'd0);
      check("rr_waddr", 32'(rf_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_wdata", 32'(rf_wdata), (i % 2 == 0) ? 32'h11 : 32'h22);
      check("rr_wen",   32'(rf_wen),   32'd1);
    end

    // Hold: nothing completes; s0 goes first on release.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 4'd0);
    check("hold_wen", 32'(rf_wen), 32'd0);
    step(1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 0, 0, 4'd0);
    check("hold_rel_waddr", 32'(rf_waddr), 32'd1);

    // Scoreboard set, clear, and set-wins-over-clear.
    do_reset();
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 1, 4'd5);
    check("sb_set5", 32'(busy[5]), 32'd1);
    step(0, 4'd0, 8'h00, 1, 4'd5, 8'h55, 0, 0, 4'd0);
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 4'd0);
    check("sb_clr5", 32'(busy[5]), 32'd0);
    step(1, 4'd7, 8'h77, 0, 4'd0, 8'h00, 0, 1, 4'd7);
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 1, 4'd7);
    check("sb_setwins7", 32'(busy[7]), 32'd1);

    // Mid-operation reset discards a registered write.
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 1, 4'd9);
    step(1, 4'd4, 8'h44, 0, 4'd0, 8'h00, 0, 0, 4'd0);
    check("mid_wen_before", 32'(rf_wen), 32'd1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("mid_wen",  32'(rf_wen), 32'd0);
    check("mid_busy", 32'(busy),   32'd0);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 4'd0);
    check("mid_no_write", 32'(rf_wen), 32'd0);

    // Register 0 behaviour depends on the build option.
    do_reset();
    step(1, 4'd0, 8'hFF, 0, 4'd0, 8'h00, 0, 0, 4'd0);
    check("r0_wen", 32'(rf_wen), R0Z ? 32'd0 : 32'd1);
    step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 1, 4'd0);
    check("r0_busy", 32'(busy[0]), R0Z ? 32'd0 : 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
           ($urandom_range(0, 2) != 0), 4'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the CPU register file. It merges writeback results from two producers (src0 = ALU, src1 = load unit) onto the single register-file write port.
- Arbitration between the two producers is round-robin, and the write port is driven from registers.
- It also keeps a busy scoreboard of destination registers with writes still outstanding, which issue logic uses for hazard stalls.

Parameters:
- DATA_PATH_WIDTH, 8, width of each register / write data.
- ADDR_WIDTH, 4, register address width (2**ADDR_WIDTH registers).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s0_valid  input  1  src0 result valid.
- s0_ready  output  1  src0 result accepted this cycle.
- s0_addr  input  ADDR_WIDTH  src0 destination register.
- s0_data  input  DATA_PATH_WIDTH  src0 result.
- s1_valid / s1_ready / s1_addr / s1_data  same as src0, for src1.
- wb_hold  input  1  freeze writeback; no handshakes complete while high.
- claim_valid  input  1  issue logic reserves a destination register.
- claim_addr  input  ADDR_WIDTH  register being reserved.
- rf_wen  output  1  register-file write enable.
- rf_waddr  output  ADDR_WIDTH  register-file write address.
- rf_wdata  output  DATA_PATH_WIDTH  register-file write data.
- busy  output  2**ADDR_WIDTH  bit i = register i has a pending write.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy=all 0.
  - Round-robin pointer set so src0 has priority on the first conflict.
- Readiness (combinational):
  - sN_ready = grantN & ~wb_hold.
  - A handshake is sN_valid & sN_ready; at most one handshake per cycle.
  - sN_ready must not depend on sN_data or sN_addr.
- Grant:
  - Only one source valid: that source is granted.
  - Both valid: the source not granted at the last accepted handshake is granted.
  - The pointer updates only on an accepted handshake, not while wb_hold is high.
- Write port, latency 1:
  - The cycle after a handshake: rf_wen=1, rf_waddr/rf_wdata = the accepted addr/data.
  - Cycle with no handshake: rf_wen=0 next cycle. rf_waddr/rf_wdata hold their previous values.
  - Back-to-back handshakes give rf_wen high on consecutive cycles; sustained throughput is 1 write/cycle.
- Scoreboard:
  - claim_valid sets busy[claim_addr] at the clock edge.
  - rf_wen clears busy[rf_waddr] at the clock edge.
  - Set and clear on the same address in the same cycle: set wins (a newer producer owns the register).
  - Claim of an already-busy register: stays 1; no counting or error.
  - Writeback to a non-busy register: performed normally; busy stays 0.
- wb_hold:
  - Both readys are forced to 0.
  - A write already registered still appears on rf_wen the following cycle.
  - Producers keep valid/data stable; no data is lost.
- Source valid deasserted before being granted: no effect; the protocol does not require valid to be held.
- Reset asserted mid-operation: the pending registered write is discarded (rf_wen=0), the scoreboard clears, and the pointer returns to src0-first.

Optional Feature:
- Macro: REGFILE_WB_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero.
  - Handshakes addressed to 0 are accepted normally, but rf_wen stays 0 for them.
  - Claims to address 0 are ignored; busy[0] is constant 0.
- Undefined: register 0 is an ordinary register; all rules above apply uniformly.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_PATH_WIDTH/ADDR_WIDTH constants;
  - NUM_REGS = 2**ADDR_WIDTH;
  - typedef of the source index (src_e: SRC_ALU=0, SRC_LOAD=1);
  - typedef of the writeback packet struct {addr, data}.
- Sub-module rr_arbiter2: 2-requester round-robin arbiter with inputs req[1:0] and advance, and output grant[1:0]. It is reusable by future read-port arbitration.

Test Plan:
- Reset and single source: reset; s0_valid=1, addr=3, data=8'hA5 for one cycle → s0_ready=1 that cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=A5; following cycle rf_wen=0.
- Conflict fairness: s0 and s1 held valid (addrs 1/2, data 11/22) for 4 cycles → grants s0,s1,s0,s1; rf writes 1:11, 2:22, 1:11, 2:22 on consecutive cycles.
- Hold: both valid, wb_hold=1 for 3 cycles → both readys 0 and rf_wen 0 from the second hold cycle onward; release → s0 granted first cycle after release (given s0 had priority before the hold).
- Scoreboard:
  - claim addr 5 → busy[5]=1 next cycle.
  - s1 writes addr 5 → busy[5]=0 the cycle after rf_wen.
  - claim 7 in the same cycle rf_wen clears 7 → busy[7]=1.
- Mid-operation reset: handshake on s0 (addr 4), then rst_n low before the next edge → rf_wen=0 immediately, busy=0, no write to 4.
- REGFILE_WB_R0_ZERO_EN build: s0 writes addr 0 data FF → s0_ready=1, rf_wen stays 0; claim 0 → busy[0]=0. Without the macro, the same stimulus gives rf_wen=1 and busy[0]=1.
